// File: rtl/ps_pkg.sv
// ps_pkg: shared PacketStream types and helpers.
//   ps_demux_state_t : demux packet-tracking state (IDLE, PASS, DROP)
//   ps_idx_valid     : true when an output index addresses an existing output
package ps_pkg;
  typedef enum logic [1:0] {IDLE, PASS, DROP} ps_demux_state_t;
  function automatic logic ps_idx_valid(input int idx, input int n);
    return idx < n;
  endfunction
endpackage

// File: rtl/ps_skid_reg.sv
// ps_skid_reg: generic 2-entry PacketStream skid buffer, full throughput, 1-cycle latency.
//   clk, reset_n         : clock, async active-low reset
//   i_val, i_rdy, i_dat  : upstream beat (i_rdy comes straight from a flop)
//   o_val, o_rdy, o_dat  : downstream beat, driven from the main register
module ps_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_val,
  output logic             i_rdy,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_val,
  input  logic             o_rdy,
  output logic [WIDTH-1:0] o_dat
);
  logic             m_val_q, m_val_d, s_val_q, s_val_d;
  logic [WIDTH-1:0] m_dat_q, m_dat_d, s_dat_q, s_dat_d;
  logic             acc_i, pop, load;
  assign i_rdy = ~s_val_q;
  assign acc_i = i_val & ~s_val_q;
  // main register may take a new beat when empty or draining; skid entry refills it first
  assign pop   = ~m_val_q | o_rdy;
  assign load  = pop & (s_val_q | acc_i);
  assign o_val = m_val_q;
  assign o_dat = m_dat_q;
  always_comb begin
    m_val_d = pop ? (s_val_q | acc_i) : m_val_q;
    m_dat_d = load ? (s_val_q ? s_dat_q : i_dat) : m_dat_q;
    s_val_d = pop ? 1'b0 : (s_val_q | acc_i);
    s_dat_d = (!pop && acc_i) ? i_dat : s_dat_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_val_q <= 1'b0;
      s_val_q <= 1'b0;
      m_dat_q <= '0;
      s_dat_q <= '0;
    end else begin
      m_val_q <= m_val_d;
      s_val_q <= s_val_d;
      m_dat_q <= m_dat_d;
      s_dat_q <= s_dat_d;
    end
endmodule

// File: rtl/ps_demux.sv
// ps_demux: PacketStream 1-to-SOURCES demultiplexer; destination fixed per packet from 'select'.
//   clk, reset_n          : clock, async active-low reset
//   select                : destination index, sampled on the first beat of a packet
//   i_dat, i_val, i_eop   : input beat; i_rdy : input ready
//   o_dat, o_val, o_eop   : per-output beats; o_rdy : per-output ready
//   o_drop                : pulse on the accepted EOP beat of a packet sent to an invalid index
//   PS_DEMUX_OUTREG_EN    : when defined, outputs come from a skid register (1-cycle latency)
module ps_demux
  import ps_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int SOURCES = 2,
  localparam int SW      = $clog2(SOURCES)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [SW-1:0]                   select,
  input  logic [WIDTH-1:0]                i_dat,
  input  logic                            i_val,
  input  logic                            i_eop,
  output logic                            i_rdy,
  output logic [SOURCES-1:0][WIDTH-1:0]   o_dat,
  output logic [SOURCES-1:0]              o_val,
  output logic [SOURCES-1:0]              o_eop,
  input  logic [SOURCES-1:0]              o_rdy,
  output logic                            o_drop
);
  localparam int NP = 1 << SW;
  ps_demux_state_t state_q;
  logic [SW-1:0]   sel_q, route;
  logic            en_q, routed, r_val, fwd_rdy;
  logic [NP-1:0]   rdy_pad;
  // pad ready so an out-of-range index reads as not ready instead of X
  assign rdy_pad = NP'(o_rdy);
  assign route   = (state_q == IDLE) ? select : sel_q;
  assign routed  = (state_q == PASS) | ((state_q == IDLE) & ps_idx_valid(int'(select), SOURCES));
  // en_q keeps the input closed until the first edge after reset release
  assign r_val   = i_val & routed & en_q;
  assign i_rdy   = en_q & (~routed | fwd_rdy);
  assign o_drop  = i_val & i_rdy & i_eop & ~routed;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      en_q <= 1'b1;
      if (i_val && i_rdy) begin
        if (state_q == IDLE && !i_eop) begin
          sel_q   <= select;
          state_q <= routed ? PASS : DROP;
        end else if (i_eop) state_q <= IDLE;
      end
    end
`ifdef PS_DEMUX_OUTREG_EN
  logic                    sk_val, sk_rdy, sk_eop;
  logic [SW-1:0]           sk_idx;
  logic [WIDTH-1:0]        sk_dat;
  logic [SW+WIDTH:0]       sk_q;
  assign {sk_idx, sk_dat, sk_eop} = sk_q;
  assign fwd_rdy = sk_rdy;
  ps_skid_reg #(.WIDTH(SW + WIDTH + 1)) u_skid (
    .clk    (clk),
    .reset_n(reset_n),
    .i_val  (r_val),
    .i_rdy  (sk_rdy),
    .i_dat  ({route, i_dat, i_eop}),
    .o_val  (sk_val),
    .o_rdy  (rdy_pad[sk_idx]),
    .o_dat  (sk_q)
  );
  for (genvar k = 0; k < SOURCES; k++) begin : g_out
    assign o_val[k] = sk_val & (sk_idx == SW'(k));
    assign o_dat[k] = sk_dat;
    assign o_eop[k] = sk_eop;
  end
`else
  assign fwd_rdy = rdy_pad[route];
  for (genvar k = 0; k < SOURCES; k++) begin : g_out
    assign o_val[k] = r_val & (route == SW'(k));
    assign o_dat[k] = i_dat;
    assign o_eop[k] = i_eop;
  end
`endif
endmodule

// File: tb/tb_ps_demux.sv
// tb_ps_demux: self-checking bench for ps_demux (SOURCES=3, so select=3 is an invalid route).
module tb_ps_demux;
  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      select;
  logic [7:0]      i_dat;
  logic            i_val, i_eop, i_rdy, o_drop;
  logic [2:0][7:0] o_dat;
  logic [2:0]      o_val, o_eop, o_rdy;

  ps_demux #(.WIDTH(8), .SOURCES(3)) dut (
    .clk(clk), .reset_n(reset_n), .select(select), .i_dat(i_dat), .i_val(i_val),
    .i_eop(i_eop), .i_rdy(i_rdy), .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop),
    .o_rdy(o_rdy), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, multi_val = 0, drop_err = 0, obs_drops = 0, exp_drops = 0;
  int stalls = 0, timeouts = 0;
  int last_hs[3];
  bit rand_rdy = 0;
  logic [8:0] exp_q[3][$];
  logic [8:0] obs_q[3][$];
  bit in_pkt = 0;
  int cur = 0, dest;
  bit acc, exp_drop;

  // Scoreboard: packet destination is the select value seen on the first accepted beat;
  // beats to an index >= 3 vanish and their EOP must coincide with o_drop.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) in_pkt = 0;
    else begin
      for (int k = 0; k < 3; k++)
        if (o_val[k] && o_rdy[k]) begin
          obs_q[k].push_back({o_eop[k], o_dat[k]});
          last_hs[k] = cyc;
        end
      if ($countones(o_val) > 1) multi_val++;
      acc      = i_val && i_rdy;
      dest     = in_pkt ? cur : int'(select);
      exp_drop = acc && i_eop && dest >= 3;
      if (o_drop !== exp_drop) drop_err++;
      if (o_drop) obs_drops++;
      if (exp_drop) exp_drops++;
      if (acc) begin
        if (dest < 3) exp_q[dest].push_back({i_eop, i_dat});
        in_pkt = !i_eop;
        cur    = dest;
      end
    end
  end

  function automatic int qdiff();
    int n = 0;
    for (int k = 0; k < 3; k++) begin
      if (exp_q[k].size() != obs_q[k].size()) n++;
      else for (int j = 0; j < exp_q[k].size(); j++) if (exp_q[k][j] !== obs_q[k][j]) n++;
    end
    return n;
  endfunction

  task automatic clear_sb();
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      obs_q[k].delete();
      last_hs[k] = 0;
    end
    multi_val = 0; drop_err = 0; obs_drops = 0; exp_drops = 0; stalls = 0; timeouts = 0;
  endtask

  task automatic send_beat(input logic [1:0] s, input logic [7:0] d, input logic e);
    int n = 0;
    select = s; i_dat = d; i_eop = e; i_val = 1'b1;
    forever begin
      if (rand_rdy) o_rdy = 3'($urandom);
      @(negedge clk);
      if (i_rdy) break;
      stalls++;
      if (++n > 50) begin timeouts++; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    i_val = 1'b0;
  endtask

  task automatic drain();
    rand_rdy = 0; o_rdy = '1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_val = 1'b1; i_eop = 1'b0; i_dat = 8'h5A; select = 2'd1; o_rdy = '1;
    repeat (2) @(negedge clk);
    checks++; if (i_rdy !== 1'b0) begin failures++; $display("FAIL reset_i_rdy got=%b exp=0", i_rdy); end
    checks++; if (o_val !== 3'b000) begin failures++; $display("FAIL reset_o_val got=%b exp=000", o_val); end
    checks++; if (o_drop !== 1'b0) begin failures++; $display("FAIL reset_o_drop got=%b exp=0", o_drop); end
`ifdef PS_DEMUX_OUTREG_EN
    checks++; if (o_dat !== '0) begin failures++; $display("FAIL reset_o_dat got=%h exp=0", o_dat); end
`endif
    @(posedge clk); #1;
    i_val = 1'b0; reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_route();
    clear_sb(); o_rdy = '1;
    send_beat(2'd2, 8'hA1, 1'b0); send_beat(2'd2, 8'hA2, 1'b0); send_beat(2'd2, 8'hA3, 1'b1);
    drain();
    checks++; if (obs_q[2].size() !== 3) begin failures++; $display("FAIL route_count got=%0d exp=3", obs_q[2].size()); end
    checks++; if (obs_q[0].size() + obs_q[1].size() !== 0) begin failures++; $display("FAIL route_other got=%0d exp=0", obs_q[0].size() + obs_q[1].size()); end
    if (obs_q[2].size() == 3) begin
      checks++; if (obs_q[2][0] !== 9'h0A1) begin failures++; $display("FAIL route_first got=%h exp=0a1", obs_q[2][0]); end
      checks++; if (obs_q[2][2] !== 9'h1A3) begin failures++; $display("FAIL route_eop got=%h exp=1a3", obs_q[2][2]); end
    end
    checks++; if (qdiff() !== 0) begin failures++; $display("FAIL route_sb got=%0d exp=0", qdiff()); end
  endtask

  task automatic test_select_hold();
    clear_sb(); o_rdy = '1;
    send_beat(2'd2, 8'hC1, 1'b0); send_beat(2'd0, 8'hC2, 1'b0); send_beat(2'd0, 8'hC3, 1'b1);
    send_beat(2'd0, 8'hD1, 1'b0); send_beat(2'd2, 8'hD2, 1'b1);
    drain();
    checks++; if (obs_q[2].size() !== 3) begin failures++; $display("FAIL hold_out2 got=%0d exp=3", obs_q[2].size()); end
    checks++; if (obs_q[0].size() !== 2) begin failures++; $display("FAIL hold_out0 got=%0d exp=2", obs_q[0].size()); end
    checks++; if (qdiff() !== 0) begin failures++; $display("FAIL hold_sb got=%0d exp=0", qdiff()); end
  endtask

  task automatic test_drop();
    clear_sb(); o_rdy = '1;
    for (int b = 0; b < 4; b++) send_beat(2'd3, 8'hE0 + 8'(b), b == 3);
    drain();
    checks++; if (stalls !== 0) begin failures++; $display("FAIL drop_stall got=%0d exp=0", stalls); end
    checks++; if (obs_q[0].size() + obs_q[1].size() + obs_q[2].size() !== 0) begin failures++; $display("FAIL drop_out got=%0d exp=0", obs_q[0].size() + obs_q[1].size() + obs_q[2].size()); end
    checks++; if (obs_drops !== 1) begin failures++; $display("FAIL drop_pulses got=%0d exp=1", obs_drops); end
    checks++; if (drop_err !== 0) begin failures++; $display("FAIL drop_timing got=%0d exp=0", drop_err); end
  endtask

  task automatic test_backpressure();
    logic [7:0] held = '0;
    int idx = 2;
    bit ever_rdy = 0, ok;
    clear_sb(); o_rdy = '1;
    send_beat(2'd1, 8'hB0, 1'b0); send_beat(2'd1, 8'hB1, 1'b0);
    o_rdy[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      select = 2'd0; i_dat = 8'hB0 + 8'(idx); i_eop = 1'b0; i_val = 1'b1;
      @(negedge clk);
      ok = i_rdy;
      if (i_rdy) ever_rdy = 1;
      if (c == 2) held = o_dat[1];
      if (c > 2) begin
        checks++; if (o_val[1] !== 1'b1 || o_dat[1] !== held) begin failures++; $display("FAIL bp_hold got=%b/%h exp=1/%h", o_val[1], o_dat[1], held); end
      end
      if (c == 4) begin
        checks++; if (i_rdy !== 1'b0) begin failures++; $display("FAIL bp_i_rdy got=%b exp=0", i_rdy); end
      end
      @(posedge clk); #1;
      if (ok) idx++;
    end
`ifndef PS_DEMUX_OUTREG_EN
    checks++; if (ever_rdy !== 1'b0) begin failures++; $display("FAIL bp_comb_rdy got=%b exp=0", ever_rdy); end
`endif
    o_rdy = '1;
    for (int j = idx; j < 6; j++) send_beat(2'd0, 8'hB0 + 8'(j), j == 5);
    drain();
    checks++; if (obs_q[1].size() !== 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", obs_q[1].size()); end
    checks++; if (qdiff() !== 0) begin failures++; $display("FAIL bp_sb got=%0d exp=0", qdiff()); end
  endtask

  task automatic test_back_to_back();
    clear_sb(); o_rdy = '1;
    send_beat(2'd0, 8'h11, 1'b1); send_beat(2'd1, 8'h22, 1'b1);
    drain();
    checks++; if (last_hs[1] - last_hs[0] !== 1) begin failures++; $display("FAIL b2b_gap got=%0d exp=1", last_hs[1] - last_hs[0]); end
    checks++; if (qdiff() !== 0 || obs_q[0].size() !== 1 || obs_q[1].size() !== 1) begin failures++; $display("FAIL b2b_sb got=%0d/%0d exp=1/1", obs_q[0].size(), obs_q[1].size()); end
  endtask

  task automatic test_reset_mid();
    o_rdy = '1;
    send_beat(2'd2, 8'hF1, 1'b0); send_beat(2'd2, 8'hF2, 1'b0);
    select = 2'd2; i_dat = 8'hF3; i_eop = 1'b0; i_val = 1'b1; reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (o_val !== 3'b000 || i_rdy !== 1'b0) begin failures++; $display("FAIL rst_mid got=%b/%b exp=000/0", o_val, i_rdy); end
    end
    @(posedge clk); #1;
    i_val = 1'b0; reset_n = 1'b1;
    clear_sb();
    send_beat(2'd1, 8'h71, 1'b0); send_beat(2'd2, 8'h72, 1'b1);
    drain();
    checks++; if (obs_q[1].size() !== 2 || obs_q[2].size() !== 0) begin failures++; $display("FAIL rst_new got=%0d/%0d exp=2/0", obs_q[1].size(), obs_q[2].size()); end
    checks++; if (qdiff() !== 0) begin failures++; $display("FAIL rst_sb got=%0d exp=0", qdiff()); end
  endtask

  task automatic test_random();
    int len;
    clear_sb(); rand_rdy = 1;
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) send_beat(2'($urandom_range(0, 3)), 8'($urandom), b == len - 1);
    end
    drain();
    checks++; if (qdiff() !== 0) begin failures++; $display("FAIL rand_sb got=%0d exp=0", qdiff()); end
    checks++; if (obs_drops !== exp_drops || drop_err !== 0) begin failures++; $display("FAIL rand_drop got=%0d/%0d exp=%0d/0", obs_drops, drop_err, exp_drops); end
    checks++; if (multi_val !== 0) begin failures++; $display("FAIL rand_onehot got=%0d exp=0", multi_val); end
    checks++; if (timeouts !== 0) begin failures++; $display("FAIL rand_timeout got=%0d exp=0", timeouts); end
  endtask

  initial begin
    reset_n = 1'b0; i_val = 1'b0; i_eop = 1'b0; i_dat = '0; select = '0; o_rdy = '1;
    test_reset();
    test_route();
    test_select_hold();
    test_drop();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
